// File: rtl/alu_result_collector_if.sv
// Bundle of the ALU-result capture port, the consumer read port and the status
// outputs of alu_result_collector.
// Optional macro PARITY_CHECK_EN adds the parity_err status signal.
interface alu_result_collector_if #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 4,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 8
);
   localparam int OCC_W = $clog2(DEPTH) + 1;

   // Handshakes: an ALU result is offered whenever in_valid is high (there is
   // no back-pressure; it is stored or counted as dropped). A head entry moves
   // to the consumer on any rising clock edge where rd_valid && rd_ready.
   logic              in_valid;
   logic [SEL_W-1:0]  select;
   logic [DATA_W-1:0] out;
   logic              zero;
   logic              carry;
   logic              sign;
   logic              parity;
   logic              overflow;
   logic              rd_ready;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_result;
   logic [SEL_W-1:0]  rd_select;
   logic [4:0]        rd_flags;
   logic [OCC_W-1:0]  count;
   logic              full;
   logic              empty;
   logic              clr_sticky;
   logic [4:0]        sticky_flags;
   logic [CNT_W-1:0]  drop_cnt;
`ifdef PARITY_CHECK_EN
   logic              parity_err;

   modport master (
      output in_valid, select, out, zero, carry, sign, parity, overflow,
      output rd_ready, clr_sticky,
      input  rd_valid, rd_result, rd_select, rd_flags, count, full, empty,
      input  sticky_flags, drop_cnt, parity_err
   );
   modport slave (
      input  in_valid, select, out, zero, carry, sign, parity, overflow,
      input  rd_ready, clr_sticky,
      output rd_valid, rd_result, rd_select, rd_flags, count, full, empty,
      output sticky_flags, drop_cnt, parity_err
   );
`else
   modport master (
      output in_valid, select, out, zero, carry, sign, parity, overflow,
      output rd_ready, clr_sticky,
      input  rd_valid, rd_result, rd_select, rd_flags, count, full, empty,
      input  sticky_flags, drop_cnt
   );
   modport slave (
      input  in_valid, select, out, zero, carry, sign, parity, overflow,
      input  rd_ready, clr_sticky,
      output rd_valid, rd_result, rd_select, rd_flags, count, full, empty,
      output sticky_flags, drop_cnt
   );
`endif
endinterface

// File: rtl/alu_result_collector.sv
// alu_result_collector: FIFO of ALU results {select, out, flags} drained over a
// valid/ready port, with sticky flag OR and a saturating drop counter.
// Optional macro PARITY_CHECK_EN adds a sticky parity_err check of parity vs ^out.
module alu_result_collector #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 4,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 8
) (
   input logic clk,
   input logic rst,
   alu_result_collector_if.slave bus
);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int OCC_W   = PTR_W + 1;
   localparam int ENTRY_W = SEL_W + DATA_W + 5;
   localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]   count_q, count_d;
   logic [4:0]         sticky_q, sticky_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic               full, empty, push, pop, drop;
   logic [4:0]         in_flags;
   logic [ENTRY_W-1:0] head;
`ifdef PARITY_CHECK_EN
   logic               perr_q, perr_d;
`endif

   // Handshake decode and next-state of pointers, occupancy and status.
   always_comb begin
      in_flags = {bus.overflow, bus.sign, bus.parity, bus.carry, bus.zero};
      full     = (count_q == OCC_W'(DEPTH));
      empty    = (count_q == '0);
      pop      = !empty && bus.rd_ready;
      push     = bus.in_valid && (!full || pop);
      drop     = bus.in_valid && full && !pop;

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + OCC_W'(push) - OCC_W'(pop);

      // A clear coinciding with a push/drop keeps that cycle's event.
      sticky_d = bus.clr_sticky ? 5'b0 : sticky_q;
      if (push) sticky_d = sticky_d | in_flags;

      if (bus.clr_sticky)                drop_d = drop ? CNT_W'(1) : '0;
      else if (drop && drop_q != DROP_MAX) drop_d = drop_q + 1'b1;
      else                               drop_d = drop_q;

`ifdef PARITY_CHECK_EN
      perr_d = bus.clr_sticky ? 1'b0 : perr_q;
      if (push && (bus.parity != ^bus.out)) perr_d = 1'b1;
`endif
   end

   // Control and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         sticky_q <= '0;
         drop_q   <= '0;
`ifdef PARITY_CHECK_EN
         perr_q   <= 1'b0;
`endif
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         sticky_q <= sticky_d;
         drop_q   <= drop_d;
`ifdef PARITY_CHECK_EN
         perr_q   <= perr_d;
`endif
      end
   end

   // Entry storage; contents need no reset because reads are masked when empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {bus.select, bus.out, in_flags};
   end

   // Head presentation, forced to zero while the FIFO is empty.
   always_comb begin
      head             = empty ? '0 : mem_q[rd_ptr_q];
      bus.rd_valid     = !empty;
      bus.rd_select    = head[ENTRY_W-1 -: SEL_W];
      bus.rd_result    = head[DATA_W+4 -: DATA_W];
      bus.rd_flags     = head[4:0];
      bus.count        = count_q;
      bus.full         = full;
      bus.empty        = empty;
      bus.sticky_flags = sticky_q;
      bus.drop_cnt     = drop_q;
`ifdef PARITY_CHECK_EN
      bus.parity_err   = perr_q;
`endif
   end
endmodule
